// File: rtl/alu_issue_ctrl.sv
// Single-issue sequencer for the shared ALU: condition check, ALU_LAT-cycle drive, result/flag capture.
// Optional macro ALU_ISSUE_B2B_EN lets a new request be accepted on the response handshake edge.
module alu_cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b1;
    case (cond)
      4'h0: pass = z;
      4'h1: pass = !z;
      4'h2: pass = c;
      4'h3: pass = !c;
      4'h4: pass = n;
      4'h5: pass = !n;
      4'h6: pass = v;
      4'h7: pass = !v;
      4'h8: pass = c && !z;
      4'h9: pass = !c || z;
      4'hA: pass = (n == v);
      4'hB: pass = (n != v);
      4'hC: pass = !z && (n == v);
      4'hD: pass = z || (n != v);
      default: pass = 1'b1;
    endcase
  end
endmodule

module alu_issue_ctrl #(
  parameter int DATA_W  = 32,
  parameter int CTL_W   = 11,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CTL_W-1:0]  req_ctl,
  input  logic [3:0]        req_cond,
  input  logic              req_setf,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [CTL_W-1:0]  alu_ctl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_nzcv,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_exec,
  output logic [3:0]        cpsr_nzcv
);
  // ALU_LAT is capped at 4, so a 2-bit down-counter covers every legal setting
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

  if (ALU_LAT < 1 || ALU_LAT > 4) begin : g_bad_lat
    $error("alu_issue_ctrl: ALU_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CTL_W-1:0]    ctl_q, ctl_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                setf_q, setf_d;
  logic [DATA_W-1:0]   rsp_data_d;
  logic                rsp_exec_d;
  logic [3:0]          cpsr_d;
  logic                cond_pass;
  logic                accept;
  logic                commit;
  logic                logical_op;

  alu_cond_eval u_cond (
    .cond (req_cond),
    .nzcv (cpsr_nzcv),
    .pass (cond_pass)
  );

  // Compare-type ops always write flags; logical ops leave C and V untouched
  assign commit = setf_q || (ctl_q == CTL_W'(8)) || (ctl_q == CTL_W'(9)) || (ctl_q == CTL_W'(10));
  assign logical_op = (ctl_q == CTL_W'(3)) || (ctl_q == CTL_W'(4)) || (ctl_q == CTL_W'(5)) ||
                      (ctl_q == CTL_W'(9)) || (ctl_q == CTL_W'(10)) || (ctl_q == CTL_W'(11));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctl_d      = ctl_q;
    a_d        = a_q;
    b_d        = b_q;
    setf_d     = setf_q;
    rsp_data_d = rsp_data;
    rsp_exec_d = rsp_exec;
    cpsr_d     = cpsr_nzcv;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_ctl    = '0;
    alu_a      = '0;
    alu_b      = '0;
    accept     = 1'b0;

    case (state_q)
      IDLE: req_ready = 1'b1;
      EXEC: begin
        alu_ctl = ctl_q;
        alu_a   = a_q;
        alu_b   = b_q;
        if (cnt_q == '0) begin
          rsp_data_d = alu_result;
          rsp_exec_d = 1'b1;
          state_d    = RESP;
          if (commit) begin
            cpsr_d = logical_op ? {alu_nzcv[3:2], cpsr_nzcv[1:0]} : alu_nzcv;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
`ifdef ALU_ISSUE_B2B_EN
        req_ready = rsp_ready;
`endif
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    accept = req_valid && req_ready;
    if (accept) begin
      ctl_d  = req_ctl;
      a_d    = req_a;
      b_d    = req_b;
      setf_d = req_setf;
      if (cond_pass) begin
        state_d = EXEC;
        cnt_d   = CNT_INIT;
      end else begin
        // Squashed ops skip the ALU entirely and report a zero result
        state_d    = RESP;
        rsp_data_d = '0;
        rsp_exec_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ctl_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      setf_q    <= 1'b0;
      rsp_data  <= '0;
      rsp_exec  <= 1'b0;
      cpsr_nzcv <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctl_q     <= ctl_d;
      a_q       <= a_d;
      b_q       <= b_d;
      setf_q    <= setf_d;
      rsp_data  <= rsp_data_d;
      rsp_exec  <= rsp_exec_d;
      cpsr_nzcv <= cpsr_d;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus random traffic against a timing-level model.
module tb_alu_issue_ctrl;
  localparam int DW  = 32;
  localparam int CW  = 11;
  localparam int LAT = 3;
`ifdef ALU_ISSUE_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [CW-1:0] req_ctl = '0;
  logic [3:0]    req_cond = '0;
  logic          req_setf = 1'b0;
  logic [DW-1:0] req_a = '0, req_b = '0;
  logic [CW-1:0] alu_ctl;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [3:0]    alu_nzcv;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_exec;
  logic [3:0]    cpsr_nzcv;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(DW), .CTL_W(CW), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctl(req_ctl), .req_cond(req_cond),
    .req_setf(req_setf), .req_a(req_a), .req_b(req_b),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_nzcv(alu_nzcv),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_exec(rsp_exec),
    .cpsr_nzcv(cpsr_nzcv)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural ALU: real ARM flags for add/sub, operand-derived C/V for logical ops
  function automatic logic [35:0] alu_fn(input logic [CW-1:0] ctl, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = '0; r = a ^ b; c = a[0]; v = b[0];
    case (ctl)
      11'd0: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      11'd2, 11'd8: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      11'd3, 11'd9:  r = a & b;
      11'd4:         r = a | b;
      11'd5, 11'd10: r = a ^ b;
      11'd11:        r = a & ~b;
      default:       r = a ^ b;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb {alu_nzcv, alu_result} = alu_fn(alu_ctl, alu_a, alu_b);

  function automatic bit cond_ok(input logic [3:0] cd, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cd)
      4'h0: return z;       4'h1: return !z;
      4'h2: return c;       4'h3: return !c;
      4'h4: return n;       4'h5: return !n;
      4'h6: return v;       4'h7: return !v;
      4'h8: return c && !z; 4'h9: return !c || z;
      4'hA: return n == v;  4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Reference model: one outstanding op, described by the cycle its response becomes due
  int            cyc = 0;
  bit            m_busy = 0, m_pass = 0, m_done = 0;
  int            m_ready = 0;
  logic [3:0]    m_cpsr = '0;
  logic [CW-1:0] m_ctl = '0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_data = '0;
  logic          m_setf = 1'b0;
  bit            mv, mr;
  logic [35:0]   m_out;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_busy = 0; m_cpsr = '0; cyc = 0;
    end else begin
      mv = m_busy && cyc >= m_ready;
      mr = !m_busy || (B2B && mv && rsp_ready);
      if (mv && rsp_ready) m_busy = 0;
      if (mr && req_valid) begin
        m_ctl = req_ctl; m_a = req_a; m_b = req_b; m_setf = req_setf;
        m_pass = cond_ok(req_cond, m_cpsr);
        m_out = alu_fn(m_ctl, m_a, m_b);
        m_data = m_pass ? m_out[31:0] : '0;
        m_ready = cyc + 1 + (m_pass ? LAT : 0);
        m_done = 0;
        m_busy = 1;
      end
      cyc++;
      if (m_busy && m_pass && !m_done && cyc == m_ready) begin
        m_done = 1;
        m_out = alu_fn(m_ctl, m_a, m_b);
        if (m_setf || m_ctl inside {11'd8, 11'd9, 11'd10}) begin
          if (m_ctl inside {11'd3, 11'd4, 11'd5, 11'd9, 11'd10, 11'd11}) m_cpsr[3:2] = m_out[35:34];
          else m_cpsr = m_out[35:32];
        end
      end
    end
  end

  bit cv, cr, ca;
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      cv = m_busy && cyc >= m_ready;
      cr = !m_busy || (B2B && cv && rsp_ready);
      ca = m_busy && m_pass && cyc < m_ready;
      chk("req_ready", 64'(req_ready), 64'(cr));
      chk("rsp_valid", 64'(rsp_valid), 64'(cv));
      chk("cpsr_nzcv", 64'(cpsr_nzcv), 64'(m_cpsr));
      chk("alu_ctl", 64'(alu_ctl), ca ? 64'(m_ctl) : 64'd0);
      chk("alu_a", 64'(alu_a), ca ? 64'(m_a) : 64'd0);
      chk("alu_b", 64'(alu_b), ca ? 64'(m_b) : 64'd0);
      if (cv) begin
        chk("rsp_data", 64'(rsp_data), 64'(m_data));
        chk("rsp_exec", 64'(rsp_exec), 64'(m_pass));
      end
    end
  end

  bit rnd_rdy = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rnd_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  bit tp_on = 0;
  int tp_q[$];
  initial forever begin
    @(negedge clk);
    if (tp_on && rsp_valid && rsp_ready) tp_q.push_back(cyc);
  end

  task automatic wait_accept();
    bit acc, ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #2;
      if (acc) ok = 1;
    end
    req_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [CW-1:0] ctl, input logic [3:0] cd, input logic s,
                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_ctl = ctl; req_cond = cd; req_setf = s; req_a = a; req_b = b; req_valid = 1'b1;
    wait_accept();
  endtask

  task automatic wait_rsp(output int lat, output logic [DW-1:0] d, output logic ex, output int alu_cyc);
    bit found;
    found = 0; lat = 0; d = '0; ex = 1'b0; alu_cyc = 0;
    for (int i = 1; i <= 30 && !found; i++) begin
      @(negedge clk);
      if (alu_ctl != '0) alu_cyc++;
      if (rsp_valid) begin found = 1; lat = i; d = rsp_data; ex = rsp_exec; end
    end
    if (!found) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic flush();
    @(posedge clk); #2 rsp_ready = 1'b1;
    @(posedge clk); #2 rsp_ready = 1'b0;
  endtask

  task automatic do_op(input logic [CW-1:0] ctl, input logic [3:0] cd, input logic s,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output int lat, output logic [DW-1:0] d, output logic ex, output int alu_cyc);
    send(ctl, cd, s, a, b);
    wait_rsp(lat, d, ex, alu_cyc);
    flush();
  endtask

  logic [CW-1:0] ops [9] = '{11'd0, 11'd2, 11'd3, 11'd4, 11'd5, 11'd8, 11'd9, 11'd10, 11'd11};
  int            lat, ac, vcnt;
  logic [DW-1:0] d, ra;
  logic          ex;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_exec", 64'(rsp_exec), 64'd0);
    chk("rst_cpsr", 64'(cpsr_nzcv), 64'd0);
    chk("rst_alu", 64'({alu_ctl, alu_a, alu_b} != '0), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #2;

    // ADD 5+7 with S set
    do_op(11'd0, 4'hE, 1'b1, 32'd5, 32'd7, lat, d, ex, ac);
    chk("add_lat", 64'(lat), 64'(LAT + 1));
    chk("add_data", 64'(d), 64'd12);
    chk("add_exec", 64'(ex), 64'd1);
    chk("add_cpsr", 64'(cpsr_nzcv), 64'h0);

    // CMP sets Z, EQ-conditioned SUB executes; CMP clears Z, EQ op squashed
    do_op(11'd8, 4'hE, 1'b0, 32'd3, 32'd3, lat, d, ex, ac);
    chk("cmp_eq_cpsr", 64'(cpsr_nzcv), 64'h6);
    do_op(11'd2, 4'h0, 1'b0, 32'd9, 32'd4, lat, d, ex, ac);
    chk("sub_eq_exec", 64'(ex), 64'd1);
    chk("sub_eq_data", 64'(d), 64'd5);
    do_op(11'd8, 4'hE, 1'b0, 32'd5, 32'd3, lat, d, ex, ac);
    chk("cmp_ne_cpsr", 64'(cpsr_nzcv), 64'h2);
    do_op(11'd0, 4'h0, 1'b1, 32'd1, 32'd1, lat, d, ex, ac);
    chk("squash_lat", 64'(lat), 64'd1);
    chk("squash_exec", 64'(ex), 64'd0);
    chk("squash_data", 64'(d), 64'd0);
    chk("squash_cpsr", 64'(cpsr_nzcv), 64'h2);

    // Logical ops keep C,V
    do_op(11'd0, 4'hE, 1'b1, 32'h7fffffff, 32'd1, lat, d, ex, ac);
    chk("ovf_cpsr", 64'(cpsr_nzcv), 64'h9);
    do_op(11'd3, 4'hE, 1'b1, 32'd2, 32'd3, lat, d, ex, ac);
    chk("and_cpsr", 64'(cpsr_nzcv), 64'h1);
    do_op(11'd4, 4'hE, 1'b1, 32'h80000001, 32'd1, lat, d, ex, ac);
    chk("orr_cpsr", 64'(cpsr_nzcv), 64'h9);
    chk("orr_alu_cycles", 64'(ac), 64'(LAT));
    chk("orr_data", 64'(d), 64'h80000001);

    // Response held while writeback stalls; a waiting request must not slip in
    send(11'd0, 4'hE, 1'b0, 32'd1, 32'd2);
    wait_rsp(lat, d, ex, ac);
    @(posedge clk); #2;
    req_ctl = 11'd0; req_cond = 4'hE; req_setf = 1'b0; req_a = 32'd4; req_b = 32'd5; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_data", 64'(rsp_data), 64'd3);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #2 rsp_ready = 1'b1;
    wait_accept();
    rsp_ready = 1'b0;
    wait_rsp(lat, d, ex, ac);
    chk("after_hold_data", 64'(d), 64'd9);
    flush();

    // Reset in the second EXEC cycle aborts the op
    send(11'd0, 4'hE, 1'b1, 32'h7fffffff, 32'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("abort_cpsr", 64'(cpsr_nzcv), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_alu", 64'({alu_ctl, alu_a, alu_b} != '0), 64'd0);
    chk("abort_rsp", 64'({rsp_data, rsp_exec} != '0), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) vcnt++;
    end
    chk("abort_no_rsp", 64'(vcnt), 64'd0);

    // Sustained issue rate
    @(posedge clk); #2 rsp_ready = 1'b1;
    tp_q.delete();
    tp_on = 1;
    for (int k = 0; k < 4; k++) send(11'd0, 4'hE, 1'b0, 32'(k), 32'd1);
    for (int k = 0; k < 30 && tp_q.size() < 4; k++) @(negedge clk);
    tp_on = 0;
    chk("tp_count", 64'(tp_q.size()), 64'd4);
    if (tp_q.size() == 4)
      for (int k = 1; k < 4; k++) chk("tp_period", 64'(tp_q[k] - tp_q[k-1]), 64'(B2B ? LAT + 1 : LAT + 2));

    // Random traffic
    rnd_rdy = 1;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
      ra = $urandom;
      send(ops[$urandom_range(0, 8)], 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ra, ($urandom_range(0, 3) == 0) ? ra : 32'($urandom));
    end
    @(posedge clk); #2;
    rnd_rdy = 0;
    rsp_ready = 1'b1;
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
